// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM states, default
// geometry/latency and byte-lane constants, plus the access-error rule.
package dmem_pkg;

  localparam int DEFAULT_DEPTH   = 256;
  localparam int DEFAULT_LATENCY = 4;
  localparam int BYTE_W          = 8;
  localparam int NUM_LANES       = 4;
  localparam int WORD_W          = BYTE_W * NUM_LANES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // An access faults when it is not word aligned or its word index is past
  // the end of storage. The index is compared in full so that high address
  // bits never alias onto a valid word.
  function automatic logic addr_in_error(input logic [31:0] addr,
                                         input logic [31:0] depth);
    logic [31:0] word_idx;
    word_idx = {2'b00, addr[31:2]};
    return (addr[1:0] != 2'b00) || (word_idx >= depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage for the responder: DEPTH x 32-bit words, one synchronous
// byte-enabled write port and one combinational read port. Contents are
// intentionally not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [AW-1:0]        waddr_i,
  input  logic [WORD_W-1:0]    wdata_i,
  input  logic [NUM_LANES-1:0] be_i,
  input  logic [AW-1:0]        raddr_i,
  output logic [WORD_W-1:0]    rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  // Write only the enabled byte lanes of the addressed word.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        if (be_i[k]) begin
          mem_q[waddr_i][k*BYTE_W +: BYTE_W] <= wdata_i[k*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for a CPU data port. A request is
// captured in IDLE, counted down in BUSY, performed on the final BUSY edge
// and acknowledged for one cycle in RESP.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic        ready_o,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              commit_s;
  logic              acc_err_s;
  logic              mem_we_s;
  logic [AW-1:0]     word_s;
  logic [31:0]       mem_rdata_s;

  assign word_s    = addr_q[AW+1:2];
  assign acc_err_s = addr_in_error(addr_q, 32'(DEPTH));
  // The access happens on the BUSY edge where the countdown has run out.
  assign commit_s  = (state_q == BUSY) && (cnt_q == CNT_ZERO);
  // Faulting writes never reach storage.
  assign mem_we_s  = commit_s && we_q && !acc_err_s;

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (mem_we_s),
    .waddr_i (word_s),
    .wdata_i (wdata_q),
    .be_i    (be_q),
    .raddr_i (word_s),
    .rdata_o (mem_rdata_s)
  );

  // Next-state, countdown, request capture and response formation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
          we_d    = we_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
          be_d    = be_i;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          state_d = RESP;
          ack_d   = 1'b1;
          err_d   = acc_err_s;
          if (we_q || acc_err_s) begin
            rdata_d = 32'h0000_0000;
          end else begin
            rdata_d = mem_rdata_s;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State and response registers; reset aborts any transaction in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      we_q    <= 1'b0;
      addr_q  <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
      be_q    <= 4'h0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign ready_o = (state_q == IDLE);
  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=4/DEPTH=256 instance for the
// main scenarios and a LATENCY=1/DEPTH=16 instance for the short-latency build.
module tb_dmem_responder;

  localparam int LAT     = 4;
  localparam int SPACING = LAT + 2;

  logic        clk;
  logic        rst_n;

  logic        req_a, we_a, ready_a, ack_a, err_a;
  logic [31:0] addr_a, wdata_a, rdata_a;
  logic [3:0]  be_a;

  logic        req_b, we_b, ready_b, ack_b, err_b;
  logic [31:0] addr_b, wdata_b, rdata_b;
  logic [3:0]  be_b;

  int checks;
  int failures;

  dmem_responder #(.DEPTH(256), .LATENCY(LAT)) u_dut_a (
    .clk_i(clk), .rst_i(rst_n), .req_i(req_a), .we_i(we_a), .addr_i(addr_a),
    .wdata_i(wdata_a), .be_i(be_a), .ready_o(ready_a), .ack_o(ack_a),
    .rdata_o(rdata_a), .err_o(err_a)
  );

  dmem_responder #(.DEPTH(16), .LATENCY(1)) u_dut_b (
    .clk_i(clk), .rst_i(rst_n), .req_i(req_b), .we_i(we_b), .addr_i(addr_b),
    .wdata_i(wdata_b), .be_i(be_b), .ready_o(ready_b), .ack_o(ack_b),
    .rdata_o(rdata_b), .err_o(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input bit sel, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] b);
    if (sel) begin
      req_b = r; we_b = w; addr_b = a; wdata_b = wd; be_b = b;
    end else begin
      req_a = r; we_a = w; addr_a = a; wdata_a = wd; be_a = b;
    end
  endtask

  // Called at the first falling edge after acceptance; lat counts edges after acceptance.
  task automatic wait_ack(input bit sel, output int lat, output logic [31:0] rd,
                          output logic er, output logic ack_nx);
    int n;
    n = 0; lat = -1; rd = 32'h0; er = 1'b0; ack_nx = 1'b0;
    while (lat < 0 && n < 20) begin
      if ((sel ? ack_b : ack_a) === 1'b1) begin
        lat = n;
        rd  = sel ? rdata_b : rdata_a;
        er  = sel ? err_b : err_a;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    checks++;
    if (lat < 0) begin
      failures++;
      $display("FAIL ack_timeout: got no ack within 20 edges, want ack (dut %0d)", sel);
    end else begin
      @(negedge clk);
      ack_nx = sel ? ack_b : ack_a;
    end
  endtask

  task automatic transact(input bit sel, input logic w, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] b, output int lat,
                          output logic [31:0] rd, output logic er, output logic ack_nx);
    @(negedge clk);
    drive(sel, 1'b1, w, a, wd, b);
    @(posedge clk);
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    wait_ack(sel, lat, rd, er, ack_nx);
  endtask

  task automatic test_reset();
    int lat; logic [31:0] rd; logic er, nx;
    rst_n = 1'b0;
    #13;
    checks++; if (ready_a !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", ready_a); end
    checks++; if (ack_a !== 1'b0) begin failures++; $display("FAIL reset_ack: got %b want 0", ack_a); end
    checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", err_a); end
    checks++; if (rdata_a !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h want 0", rdata_a); end
    // Release reset and present a request before the very next rising edge.
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 32'h30, 32'hA5A5_A5A5, 4'hF);
    @(posedge clk);
    #1;
    checks++; if (ready_a !== 1'b0) begin failures++; $display("FAIL first_edge_accept: ready got %b want 0", ready_a); end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    wait_ack(1'b0, lat, rd, er, nx);
    checks++; if (lat != LAT) begin failures++; $display("FAIL first_write_latency: got %0d want %0d", lat, LAT); end
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rd; logic er, nx;
    transact(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, lat, rd, er, nx);
    checks++; if (lat != LAT) begin failures++; $display("FAIL wr_latency: got %0d want %0d", lat, LAT); end
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL wr_err: got %b want 0", er); end
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL wr_rdata: got %h want 0", rd); end
    checks++; if (nx !== 1'b0) begin failures++; $display("FAIL ack_one_cycle: got %b want 0", nx); end
    transact(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, lat, rd, er, nx);
    checks++; if (lat != LAT) begin failures++; $display("FAIL rd_latency: got %0d want %0d", lat, LAT); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_data: got %h want deadbeef", rd); end
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL rd_err: got %b want 0", er); end
    checks++; if (rdata_a !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rdata_hold: got %h want deadbeef", rdata_a); end
  endtask

  task automatic test_byte_enables();
    int lat; logic [31:0] rd; logic er, nx;
    transact(1'b0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, lat, rd, er, nx);
    transact(1'b0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'h5, lat, rd, er, nx);
    transact(1'b0, 1'b0, 32'h20, 32'h0, 4'hF, lat, rd, er, nx);
    checks++; if (rd !== 32'h11BB_33DD) begin failures++; $display("FAIL be_merge: got %h want 11bb33dd", rd); end
    // A write with no lanes enabled completes normally and changes nothing.
    transact(1'b0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0, lat, rd, er, nx);
    checks++; if (lat != LAT || er !== 1'b0) begin failures++; $display("FAIL be_zero_ack: got lat=%0d err=%b want lat=%0d err=0", lat, er, LAT); end
    // Reads ignore be and return the whole word.
    transact(1'b0, 1'b0, 32'h20, 32'h0, 4'h0, lat, rd, er, nx);
    checks++; if (rd !== 32'h11BB_33DD) begin failures++; $display("FAIL be_zero_nowrite: got %h want 11bb33dd", rd); end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic er, nx;
    transact(1'b0, 1'b1, 32'h0, 32'h0102_0304, 4'hF, lat, rd, er, nx);
    transact(1'b0, 1'b0, 32'h2, 32'h0, 4'hF, lat, rd, er, nx);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL misalign_rd: got err=%b rdata=%h want err=1 rdata=0", er, rd); end
    checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL err_low_after_ack: got %b want 0", err_a); end
    transact(1'b0, 1'b0, 32'h400, 32'h0, 4'hF, lat, rd, er, nx);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL range_rd: got err=%b rdata=%h want err=1 rdata=0", er, rd); end
    transact(1'b0, 1'b1, 32'h400, 32'hFFFF_FFFF, 4'hF, lat, rd, er, nx);
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL range_wr: got err=%b want 1", er); end
    transact(1'b0, 1'b1, 32'h1, 32'hEEEE_EEEE, 4'hF, lat, rd, er, nx);
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL misalign_wr: got err=%b want 1", er); end
    transact(1'b0, 1'b0, 32'h0, 32'h0, 4'hF, lat, rd, er, nx);
    checks++; if (rd !== 32'h0102_0304 || er !== 1'b0) begin failures++; $display("FAIL word0_unchanged: got %h err=%b want 01020304 err=0", rd, er); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd; logic er, nx;
    logic exp_ready, exp_ack;
    logic [31:0] exp_rd;
    for (int i = 0; i < 8; i++) begin
      transact(1'b0, 1'b1, 32'(32'h40 + 4*i), 32'(32'hC0DE_0000 + i), 4'hF, lat, rd, er, nx);
    end
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      exp_ready = ((c % SPACING) == 0);
      exp_ack   = ((c % SPACING) == SPACING - 1);
      checks++;
      if (ready_a !== exp_ready) begin failures++; $display("FAIL b2b_ready c=%0d: got %b want %b", c, ready_a, exp_ready); end
      checks++;
      if (ack_a !== exp_ack) begin failures++; $display("FAIL b2b_ack c=%0d: got %b want %b", c, ack_a, exp_ack); end
      if (exp_ack) begin
        exp_rd = 32'(32'hC0DE_0000 + ((c - (SPACING - 1)) % 8));
        checks++;
        if (rdata_a !== exp_rd) begin failures++; $display("FAIL b2b_rdata c=%0d: got %h want %h", c, rdata_a, exp_rd); end
      end
      if (c < 23) drive(1'b0, 1'b1, 1'b0, 32'(32'h40 + 4*(c % 8)), 32'h0, 4'hF);
      else        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    end
  endtask

  task automatic test_abort();
    int lat; logic [31:0] rd; logic er, nx;
    logic seen;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'h30, 32'h1234_5678, 4'hF);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (ready_a !== 1'b1) begin failures++; $display("FAIL abort_ready: got %b want 1", ready_a); end
    checks++; if (ack_a !== 1'b0) begin failures++; $display("FAIL abort_ack: got %b want 0", ack_a); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack_a === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_ack: got %b want 0", seen); end
    transact(1'b0, 1'b0, 32'h30, 32'h0, 4'hF, lat, rd, er, nx);
    checks++; if (rd !== 32'hA5A5_A5A5) begin failures++; $display("FAIL abort_no_write: got %h want a5a5a5a5", rd); end
  endtask

  task automatic test_latency_one();
    int lat; logic [31:0] rd; logic er, nx;
    transact(1'b1, 1'b1, 32'h4, 32'hCAFE_F00D, 4'hF, lat, rd, er, nx);
    checks++; if (lat != 1) begin failures++; $display("FAIL lat1_wr_latency: got %0d want 1", lat); end
    checks++; if (nx !== 1'b0) begin failures++; $display("FAIL lat1_ack_one_cycle: got %b want 0", nx); end
    transact(1'b1, 1'b0, 32'h4, 32'h0, 4'hF, lat, rd, er, nx);
    checks++; if (lat != 1) begin failures++; $display("FAIL lat1_rd_latency: got %0d want 1", lat); end
    checks++; if (rd !== 32'hCAFE_F00D) begin failures++; $display("FAIL lat1_rd_data: got %h want cafef00d", rd); end
    transact(1'b1, 1'b0, 32'h40, 32'h0, 4'hF, lat, rd, er, nx);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL lat1_range: got err=%b rdata=%h want err=1 rdata=0", er, rd); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    test_reset();
    test_write_read();
    test_byte_enables();
    test_errors();
    test_back_to_back();
    test_abort();
    test_latency_one();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
